// File: rtl/hex_entry_ctrl_if.sv
// rtl/hex_entry_ctrl_if.sv - board-side signal bundle for the decimal entry controller
//
// Signals:
//   KEY        push-buttons, active-low (0 = pressed), asynchronous to the clock
//   HEX0..HEX3 seven-segment digits, active-low, bit6..bit0 = a..g, HEX0 rightmost
// Modports:
//   master     the board / stimulus side: drives KEY, observes HEX
//   slave      the controller side: samples KEY, drives HEX
interface hex_entry_ctrl_if;
    logic [3:0] KEY;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;

    modport master (
        output KEY,
        input  HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  KEY,
        output HEX0, HEX1, HEX2, HEX3
    );
endinterface

// File: rtl/hex_entry_ctrl.sv
// rtl/hex_entry_ctrl.sv - four-digit BCD entry controller driven by debounced push-buttons
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a key level is accepted (>= 2)
//   BLINK_CYCLES     cursor blink half-period in cycles (>= 2)
// Ports:
//   CLOCK_50  system clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   bus       slave side of hex_entry_ctrl_if (KEY in, HEX0..HEX3 out)
// Keys: KEY3 clear, KEY2 cursor left, KEY1 decrement, KEY0 increment.
module hex_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic            CLOCK_50,
    input  logic            rst,
    hex_entry_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]    SEG_ZERO   = 7'b0000001;

    logic [3:0]       sync1;
    logic [3:0]       k_s;
    logic [3:0]       d;
    logic [3:0]       d_q;
    logic [DW-1:0]    deb_cnt [4];
    logic [3:0]       press;
    logic [3:0][3:0]  digits;
    logic [1:0]       cursor;
    logic [BW-1:0]    blink_cnt;
    logic             phase;
    logic [6:0]       hex_next [4];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Synchronizer stores the inverted (active-high) key level so that reset
    // value 0 means "released" and a key held through reset re-fires.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            k_s   <= '0;
        end else begin
            sync1 <= ~bus.KEY;
            k_s   <= sync1;
        end
    end

    // Counter tracks consecutive disagreeing cycles; any agreeing cycle restarts it.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            d   <= '0;
            d_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            d_q <= d;
            for (int i = 0; i < 4; i++) begin
                if (k_s[i] != d[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        d[i]       <= k_s[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = d & ~d_q;

    // Highest-index press wins; lower simultaneous presses are dropped.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            digits <= '0;
            cursor <= '0;
        end else if (press[3]) begin
            digits <= '0;
            cursor <= '0;
        end else if (press[2]) begin
            cursor <= cursor + 2'd1;
        end else if (press[1]) begin
            digits[cursor] <= (digits[cursor] == 4'd0) ? 4'd9 : digits[cursor] - 4'd1;
        end else if (press[0]) begin
            digits[cursor] <= (digits[cursor] == 4'd9) ? 4'd0 : digits[cursor] + 4'd1;
        end
    end

    // Any executed command restarts the blink so the edited digit is visible at once.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (|press) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_next[i] = (cursor == 2'(i) && !phase) ? SEG_BLANK : seg7(digits[i]);
        end
    end

    // Reset value matches the reset state (digit 0 shown) so the display is
    // correct the instant rst asserts.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            bus.HEX0 <= SEG_ZERO;
            bus.HEX1 <= SEG_ZERO;
            bus.HEX2 <= SEG_ZERO;
            bus.HEX3 <= SEG_ZERO;
        end else begin
            bus.HEX0 <= hex_next[0];
            bus.HEX1 <= hex_next[1];
            bus.HEX2 <= hex_next[2];
            bus.HEX3 <= hex_next[3];
        end
    end
endmodule

// File: tb/tb_hex_entry_ctrl.sv
// tb/tb_hex_entry_ctrl.sv - directed self-checking bench for hex_entry_ctrl
module tb_hex_entry_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    logic [6:0] seg_tab [10];

    hex_entry_ctrl_if bus ();

    hex_entry_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8)
    ) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_of(input int i);
        case (i)
            0:       hex_of = bus.HEX0;
            1:       hex_of = bus.HEX1;
            2:       hex_of = bus.HEX2;
            default: hex_of = bus.HEX3;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Key goes low just after an edge, so the next edge is E0; returns just
    // after E0+7, when the resulting display update is visible.
    task automatic hit(input int idx);
        bus.KEY[idx] = 1'b0;
        tick(8);
        bus.KEY = 4'hF;
    endtask

    task automatic settle();
        tick(10);
    endtask

    task automatic tap(input int idx);
        hit(idx);
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.KEY = 4'hF;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hex_of(i) !== seg_tab[0]) begin
                errors++;
                $display("FAIL reset_hold HEX%0d got %b want %b", i, hex_of(i), seg_tab[0]);
            end
        end
        rst = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hex_of(i) !== seg_tab[0]) begin
                errors++;
                $display("FAIL reset_idle HEX%0d got %b want %b", i, hex_of(i), seg_tab[0]);
            end
        end
        tick(5);
        checks++;
        if (bus.HEX0 !== seg_tab[0]) begin
            errors++;
            $display("FAIL blink_pre_blank got %b want %b", bus.HEX0, seg_tab[0]);
        end
        tick(1);
        checks++;
        if (bus.HEX0 !== BLANK) begin
            errors++;
            $display("FAIL blink_blank got %b want %b", bus.HEX0, BLANK);
        end
        checks++;
        if (bus.HEX1 !== seg_tab[0]) begin
            errors++;
            $display("FAIL blink_noncursor got %b want %b", bus.HEX1, seg_tab[0]);
        end
        tick(7);
        checks++;
        if (bus.HEX0 !== BLANK) begin
            errors++;
            $display("FAIL blink_still_blank got %b want %b", bus.HEX0, BLANK);
        end
        tick(1);
        checks++;
        if (bus.HEX0 !== seg_tab[0]) begin
            errors++;
            $display("FAIL blink_return got %b want %b", bus.HEX0, seg_tab[0]);
        end
    endtask

    task automatic test_increment();
        logic [6:0] exp;
        for (int n = 1; n <= 10; n++) begin
            exp = seg_tab[n % 10];
            bus.KEY[0] = 1'b0;
            tick(7);
            checks++;
            if (bus.HEX0 === exp) begin
                errors++;
                $display("FAIL inc_early step %0d got %b must not yet be %b", n, bus.HEX0, exp);
            end
            tick(1);
            checks++;
            if (bus.HEX0 !== exp) begin
                errors++;
                $display("FAIL inc_update step %0d got %b want %b", n, bus.HEX0, exp);
            end
            tick(2);
            bus.KEY = 4'hF;
            settle();
        end
    endtask

    task automatic test_dec_cursor();
        hit(1);
        checks++;
        if (bus.HEX0 !== seg_tab[9]) begin
            errors++;
            $display("FAIL dec_wrap got %b want %b", bus.HEX0, seg_tab[9]);
        end
        settle();
        tap(2);
        hit(0);
        checks++;
        if (bus.HEX1 !== seg_tab[1]) begin
            errors++;
            $display("FAIL cursor1_inc got %b want %b", bus.HEX1, seg_tab[1]);
        end
        checks++;
        if (bus.HEX0 !== seg_tab[9]) begin
            errors++;
            $display("FAIL cursor1_hex0 got %b want %b", bus.HEX0, seg_tab[9]);
        end
        settle();
        for (int k = 0; k < 3; k++) begin
            tap(2);
        end
        hit(2);
        tick(7);
        checks++;
        if (bus.HEX1 !== seg_tab[1]) begin
            errors++;
            $display("FAIL cursor_wrap_shown got %b want %b", bus.HEX1, seg_tab[1]);
        end
        tick(1);
        checks++;
        if (bus.HEX1 !== BLANK) begin
            errors++;
            $display("FAIL cursor_wrap_blank got %b want %b", bus.HEX1, BLANK);
        end
        checks++;
        if (bus.HEX2 !== seg_tab[0]) begin
            errors++;
            $display("FAIL cursor_wrap_hex2 got %b want %b", bus.HEX2, seg_tab[0]);
        end
        settle();
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 10; k++) begin
            bus.KEY[0] = 1'b0;
            tick(2);
            bus.KEY[0] = 1'b1;
            tick(2);
        end
        settle();
        checks++;
        if (bus.HEX0 !== seg_tab[9]) begin
            errors++;
            $display("FAIL bounce_hex0 got %b want %b", bus.HEX0, seg_tab[9]);
        end
        bus.KEY[0] = 1'b0;
        tick(8);
        checks++;
        if (bus.HEX1 !== seg_tab[2]) begin
            errors++;
            $display("FAIL held_single_inc got %b want %b", bus.HEX1, seg_tab[2]);
        end
        tick(2);
        bus.KEY = 4'hF;
        tick(5);
        checks++;
        if (bus.HEX1 !== seg_tab[2]) begin
            errors++;
            $display("FAIL held_no_repeat got %b want %b", bus.HEX1, seg_tab[2]);
        end
        settle();
    endtask

    task automatic test_priority();
        tap(3);
        for (int k = 0; k < 3; k++) tap(1);
        tap(2);
        tap(2);
        for (int k = 0; k < 3; k++) tap(0);
        tap(2);
        for (int k = 0; k < 4; k++) tap(0);
        hit(0);
        checks++;
        if (bus.HEX3 !== seg_tab[5]) begin
            errors++;
            $display("FAIL setup_hex3 got %b want %b", bus.HEX3, seg_tab[5]);
        end
        checks++;
        if (bus.HEX2 !== seg_tab[3]) begin
            errors++;
            $display("FAIL setup_hex2 got %b want %b", bus.HEX2, seg_tab[3]);
        end
        checks++;
        if (bus.HEX0 !== seg_tab[7]) begin
            errors++;
            $display("FAIL setup_hex0 got %b want %b", bus.HEX0, seg_tab[7]);
        end
        settle();
        bus.KEY = 4'b0110;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hex_of(i) !== seg_tab[0]) begin
                errors++;
                $display("FAIL prio_clear HEX%0d got %b want %b", i, hex_of(i), seg_tab[0]);
            end
        end
        bus.KEY = 4'hF;
        tick(8);
        checks++;
        if (bus.HEX0 !== BLANK) begin
            errors++;
            $display("FAIL prio_cursor0 got %b want %b", bus.HEX0, BLANK);
        end
        checks++;
        if (bus.HEX3 !== seg_tab[0]) begin
            errors++;
            $display("FAIL prio_hex3 got %b want %b", bus.HEX3, seg_tab[0]);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tap(0);
        hit(0);
        checks++;
        if (bus.HEX0 !== seg_tab[4]) begin
            errors++;
            $display("FAIL pre_rst_digit got %b want %b", bus.HEX0, seg_tab[4]);
        end
        settle();
        bus.KEY[0] = 1'b0;
        tick(3);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.HEX0 !== seg_tab[0]) begin
            errors++;
            $display("FAIL async_rst got %b want %b", bus.HEX0, seg_tab[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(7);
        checks++;
        if (bus.HEX0 !== seg_tab[0]) begin
            errors++;
            $display("FAIL held_rst_early got %b want %b", bus.HEX0, seg_tab[0]);
        end
        tick(1);
        checks++;
        if (bus.HEX0 !== seg_tab[1]) begin
            errors++;
            $display("FAIL held_rst_inc got %b want %b", bus.HEX0, seg_tab[1]);
        end
        tick(2);
        bus.KEY = 4'hF;
        tick(4);
        checks++;
        if (bus.HEX0 !== seg_tab[1]) begin
            errors++;
            $display("FAIL held_rst_once got %b want %b", bus.HEX0, seg_tab[1]);
        end
        settle();
    endtask

    initial begin
        seg_tab[0] = 7'b0000001;
        seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100;
        seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000;
        seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        rst = 1'b1;
        bus.KEY = 4'hF;
        test_reset();
        test_increment();
        test_dec_cursor();
        test_bounce();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_entry_ctrl.md
# hex_entry_ctrl

Four-digit decimal entry controller for the DE-board push-buttons and seven-segment displays. It debounces the four active-low KEY inputs and turns each clean press into one edit command: increment, decrement, move cursor, or clear. It holds four BCD digits and drives HEX3..HEX0 with active-low segment patterns, blanking the digit under the cursor in a blink cycle. It sits between the raw board buttons and the displays.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a key level is accepted (20 ms at 50 MHz); minimum 2
- BLINK_CYCLES, 12500000, cursor blink half-period in cycles (250 ms at 50 MHz); minimum 2
- CLOCK_50  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- KEY  in  4  push-buttons, active-low (0 = pressed), asynchronous to CLOCK_50
- HEX0  out  7  digit 0 (rightmost) segments, active-low, bit6..bit0 = a..g
- HEX1  out  7  digit 1 segments, same encoding
- HEX2  out  7  digit 2 segments, same encoding
- HEX3  out  7  digit 3 (leftmost) segments, same encoding

## Operation
- Segment patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Blank = 1111111.
- Each KEY bit passes through a 2-FF synchronizer. The synchronized value is then inverted to active-high, giving k_s[i].
- Per-key debounce:
  - The block holds a debounced level d[i] (reset 0) and a counter.
  - The counter counts cycles where k_s[i] != d[i] and clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, d[i] takes the value of k_s[i] and the counter clears.
  - A 0->1 transition of d[i] raises press[i] for exactly one cycle. Release produces no event.
- Command decode on press[3:0]. If several pulses arrive in the same cycle, only the highest index is executed and the rest are discarded:
  - KEY3: clear. All digits go to 0 and the cursor goes to 0.
  - KEY2: cursor left. 0->1->2->3->0.
  - KEY1: decrement the digit at the cursor. 0 wraps to 9.
  - KEY0: increment the digit at the cursor. 9 wraps to 0.
- Digits are 4-bit BCD registers and hold only 0..9. The cursor is 2 bits.
- Blink:
  - A free-running counter counts 0..BLINK_CYCLES-1. At each wrap, phase toggles.
  - Phase 1 means the cursor digit is shown; phase 0 means it is blanked.
  - Every executed command resets the blink counter to 0 and phase to 1.
  - Non-cursor digits are always shown.
- HEX outputs are registered from the digit, cursor and phase state.
- Reset values: digits 0000, cursor 0, phase 1, blink counter 0, d=0, debounce counters 0, synchronizers 0 (released). All HEX outputs read 0000001 immediately on rst assertion, without waiting for a clock.
- rst asserted mid-debounce or mid-blink aborts the activity with no residual event.
- A key held through reset release is treated as a new press: it fires once after the synchronizer and debounce latency.

## Timing
- Let edge E0 be the first rising edge that samples KEY[i]=0.
  - k_s[i]=1 after edge E0+1.
  - d[i] rises at edge E0+1+DEBOUNCE_CYCLES.
  - press[i] is high during the following cycle.
  - Digit or cursor state updates at edge E0+2+DEBOUNCE_CYCLES.
  - HEX shows the new value after edge E0+3+DEBOUNCE_CYCLES.
- A bounce lasting fewer than DEBOUNCE_CYCLES cycles produces no event, in either direction.
- A held key produces exactly one event. No auto-repeat.
- Blink: the cursor digit alternates between shown and blank every BLINK_CYCLES cycles, with one extra cycle of output-register latency.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
- Reset, then idle 3 cycles -> HEX0..HEX3 = 0000001. HEX0 goes blank (1111111) 8 cycles after the blink counter starts and returns to 0000001 after 8 more.
- Press KEY0 (KEY=1110) for 10 cycles, release, then repeat 9 more times -> HEX0 steps through 1..9 and back to 0. Each update occurs exactly 7 edges after the press is first sampled.
- KEY1 press from 0 -> HEX0 = 0000100 (9). Then KEY2 then KEY0 -> HEX1 = 1001111 (1), cursor 1. Four more KEY2 presses -> cursor wraps back to 1.
- KEY0 toggled low/high every 2 cycles for 40 cycles -> no digit change. Held low 10 cycles -> exactly one increment.
- KEY3 and KEY0 pressed in the same cycle, with digits 5,3,0,7 -> all digits read 0, cursor 0, no increment.
- Assert rst for 1 cycle during a held KEY0 with digit 4 -> HEX0 = 0000001 asynchronously. After release, with KEY0 still held -> one increment to 1.
